spi_shift: RTL

- Serial data engine directly downstream of spi_clgen in the SPI master.
- Consumes the clock generator's single-cycle edge strobes (cpol_0 on sclk rising, cpol_1 on sclk falling).
- Shifts a parallel word out on mosi while capturing miso into a parallel receive word.
- Drives tip and lstclk back to spi_clgen so sclk starts and stops on exact bit boundaries.

---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_shift.sv | 126 ++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master serial datapath.
//   MAX_LEN   : maximum character length in bits (also data word width)
//   CNT_W     : bit counter width, 2**CNT_W > MAX_LEN
//   IDX_W     : width of a bit index into a MAX_LEN-wide word
//   state_e   : shift engine state encoding (IDLE / XFER)
//   eff_len   : decode of the len field (0 or oversize -> MAX_LEN)
//   bit_index : transfer position k -> word bit index (LSB/MSB first)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int MAX_LEN = 32;
    localparam int CNT_W   = 6;
    localparam int IDX_W   = $clog2(MAX_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Length field decode: 0 means a full-width character, and anything
    // beyond the word width is clamped to it.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if (len == '0 || len > CNT_W'(MAX_LEN)) begin
            return CNT_W'(MAX_LEN);
        end
        return len;
    endfunction

    // Position k of an l-bit character maps to bit k (LSB first) or
    // bit l-1-k (MSB first). Both tx and rx words use this mapping.
    function automatic logic [IDX_W-1:0] bit_index(input logic [CNT_W-1:0] k,
                                                   input logic [CNT_W-1:0] l,
                                                   input logic             lsb);
        logic [CNT_W-1:0] r;
        r = lsb ? k : (l - CNT_W'(1) - k);
        return r[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/spi_shift.sv
// -----------------------------------------------------------------------------
// spi_shift
// Serial shift engine of the SPI master. Driven by the single-cycle sclk edge
// strobes of the clock generator, it shifts tx_data out on mosi and assembles
// miso into rx_data, and reports tip/lstclk back so sclk starts and stops on
// bit boundaries.
// Ports:
//   wb_clk, wb_reset      : system clock, asynchronous active-high reset
//   go                    : start request, honoured only while idle
//   len, lsb              : character length (0 = MAX_LEN), bit order
//   tx_negedge/rx_negedge : select which strobe shifts mosi / samples miso
//   cpol_0, cpol_1        : sclk rising / falling edge strobes
//   tx_data, miso         : parallel word to send, serial input
//   tip, lstclk           : transfer in progress, final sample edge pending
//   mosi, rx_data, done   : serial output, received word, completion pulse
// -----------------------------------------------------------------------------
module spi_shift
    import spi_pkg::*;
(
    input  logic               wb_clk,
    input  logic               wb_reset,
    input  logic               go,
    input  logic [CNT_W-1:0]   len,
    input  logic               lsb,
    input  logic               tx_negedge,
    input  logic               rx_negedge,
    input  logic               cpol_0,
    input  logic               cpol_1,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               miso,
    output logic               tip,
    output logic               lstclk,
    output logic               mosi,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               done
);

    state_e             state_q;
    logic [MAX_LEN-1:0] tx_q;
    logic [MAX_LEN-1:0] rx_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   ktx_q;
    logic [CNT_W-1:0]   krx_q;
    logic               lsb_q;
    logic               tip_q;
    logic               lst_q;
    logic               mosi_q;
    logic               done_q;

    logic               tx_edge;
    logic               rx_edge;
    logic [CNT_W-1:0]   len_d;
    logic [CNT_W-1:0]   last_q;

    assign tx_edge = tx_negedge ? cpol_1 : cpol_0;
    assign rx_edge = rx_negedge ? cpol_1 : cpol_0;
    assign len_d   = eff_len(len);
    assign last_q  = len_q - CNT_W'(1);

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            len_q   <= '0;
            ktx_q   <= '0;
            krx_q   <= '0;
            lsb_q   <= 1'b0;
            tip_q   <= 1'b0;
            lst_q   <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // done_q blocks a go that arrives in the very cycle tip
                    // drops, so back-to-back starts are one cycle apart.
                    if (go && !done_q) begin
                        state_q <= XFER;
                        tx_q    <= tx_data;
                        rx_q    <= '0;
                        len_q   <= len_d;
                        lsb_q   <= lsb;
                        ktx_q   <= '0;
                        krx_q   <= '0;
                        tip_q   <= 1'b1;
                        lst_q   <= (len_d == CNT_W'(1));
                        // First bit is presented before any sclk edge.
                        mosi_q  <= tx_data[bit_index('0, len_d, lsb)];
                    end
                end
                XFER: begin
                    // Once the last bit is on mosi, further shift edges
                    // are ignored so mosi holds through the final sample.
                    if (tx_edge && ktx_q < last_q) begin
                        ktx_q  <= ktx_q + CNT_W'(1);
                        mosi_q <= tx_q[bit_index(ktx_q + CNT_W'(1), len_q, lsb_q)];
                    end
                    if (rx_edge) begin
                        rx_q[bit_index(krx_q, len_q, lsb_q)] <= miso;
                        krx_q <= krx_q + CNT_W'(1);
                        if (krx_q == last_q) begin
                            state_q <= IDLE;
                            tip_q   <= 1'b0;
                            lst_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // lstclk tracks k_rx == L-1 in the same cycle
                            // the counter reaches it.
                            lst_q <= (krx_q + CNT_W'(1) == last_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tip     = tip_q;
    assign lstclk  = lst_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_q;
    assign done    = done_q;

endmodule
